// File: rtl/wb_slave_bridge_if.sv
// WISHBONE classic bus bundle between a master and wb_slave_bridge.
// Signal names follow the slave's point of view.
interface wb_slave_bridge_if #(
  parameter int DW = 32,
  parameter int AW = 26
);
  logic            cyc_i;
  logic            stb_i;
  logic            we_i;
  logic [AW-1:0]   adr_i;
  logic [DW/8-1:0] sel_i;
  logic [DW-1:0]   dat_i;
  logic [DW-1:0]   dat_o;
  logic            ack_o;
  logic            err_o;
  logic            tagd_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, err_o, tagd_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, err_o, tagd_o
  );
endinterface

// File: rtl/wb_slave_bridge.sv
// WISHBONE classic slave routing each transfer to a word memory or a narrow SSP peripheral.
// Define WB_SLV_TIMEOUT_EN to abandon SSP accesses with err_o after TMO_CYC cycles without ssp_rdy_i.
module wb_slave_bridge #(
  parameter int DW       = 32,
  parameter int AW       = 26,
  parameter int SEL_BIT  = 16,
  parameter int NARROW_W = 8,
  parameter int WAIT_CYC = 1,
  parameter int TMO_CYC  = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  wb_slave_bridge_if.slave    wb,
  output logic [AW-1:0]       mem_adr_o,
  output logic [DW/8-1:0]     mem_sel_o,
  output logic [DW-1:0]       mem_dat_o,
  input  logic [DW-1:0]       mem_dat_i,
  output logic                mem_r_o,
  output logic                mem_w_o,
  output logic [NARROW_W-1:0] ssp_dat_o,
  input  logic [NARROW_W-1:0] ssp_dat_i,
  input  logic                ssp_rdy_i,
  output logic                ssp_sel_o,
  output logic                ssp_w_o
);
  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  if (WAIT_CYC < 1 || SEL_BIT >= AW || NARROW_W > DW || TMO_CYC < 1) begin : g_bad_params
    $error("wb_slave_bridge: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_ACK, S_ERR} state_t;

  state_t          state_q;
  logic            we_q;
  logic            ssp_q;
  logic [CW-1:0]   wcnt_q;
  logic [AW-1:0]   adr_q;
  logic [DW/8-1:0] sel_q;
  logic [DW-1:0]   wdat_q;
  logic [DW-1:0]   rdata_q;
  logic            ack_q;
  logic            tagd_q;
  logic            mem_r_q;
  logic            mem_w_q;
  logic            ssp_sel_q;
  logic            ssp_w_q;

  logic            req;
  logic            abort;
  logic            wait_done;
  logic [DW-1:0]   rd_data;

  assign req       = wb.cyc_i & wb.stb_i;
  assign abort     = ((state_q == S_SETUP) || (state_q == S_WAIT)) && !wb.cyc_i;
  assign wait_done = (wcnt_q == '0) && (!ssp_q || ssp_rdy_i);
  assign rd_data   = ssp_q ? DW'(ssp_dat_i) : mem_dat_i;

`ifdef WB_SLV_TIMEOUT_EN
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  logic [TW-1:0] tmo_q;
  logic          err_q;
  logic          tmo_hit;
  assign tmo_hit   = ssp_q && (tmo_q == TW'(TMO_CYC - 1));
  assign wb.err_o  = err_q;
`else
  assign wb.err_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      ssp_q     <= 1'b0;
      wcnt_q    <= '0;
      adr_q     <= '0;
      sel_q     <= '0;
      wdat_q    <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      tagd_q    <= 1'b0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      ssp_sel_q <= 1'b0;
      ssp_w_q   <= 1'b0;
`ifdef WB_SLV_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      ack_q  <= 1'b0;
      tagd_q <= 1'b0;
`ifdef WB_SLV_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      if (abort) begin
        // Master gave up mid-transfer: silently drop the access, keep dat_o.
        state_q   <= S_IDLE;
        mem_r_q   <= 1'b0;
        mem_w_q   <= 1'b0;
        ssp_sel_q <= 1'b0;
        ssp_w_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (req) begin
              adr_q     <= wb.adr_i;
              sel_q     <= wb.sel_i;
              wdat_q    <= wb.dat_i;
              we_q      <= wb.we_i;
              ssp_q     <= wb.adr_i[SEL_BIT];
              mem_r_q   <= !wb.adr_i[SEL_BIT] && !wb.we_i;
              mem_w_q   <= !wb.adr_i[SEL_BIT] &&  wb.we_i;
              ssp_sel_q <=  wb.adr_i[SEL_BIT];
              ssp_w_q   <=  wb.adr_i[SEL_BIT] &&  wb.we_i;
              state_q   <= S_SETUP;
            end
          end
          S_SETUP: begin
            wcnt_q  <= CW'(WAIT_CYC - 1);
`ifdef WB_SLV_TIMEOUT_EN
            tmo_q   <= '0;
`endif
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (wait_done) begin
              mem_r_q   <= 1'b0;
              mem_w_q   <= 1'b0;
              ssp_sel_q <= 1'b0;
              ssp_w_q   <= 1'b0;
              ack_q     <= 1'b1;
              tagd_q    <= ssp_q && !we_q;
              if (!we_q) begin
                rdata_q <= rd_data;
              end
              state_q   <= S_ACK;
`ifdef WB_SLV_TIMEOUT_EN
            end else if (tmo_hit) begin
              mem_r_q   <= 1'b0;
              mem_w_q   <= 1'b0;
              ssp_sel_q <= 1'b0;
              ssp_w_q   <= 1'b0;
              err_q     <= 1'b1;
              state_q   <= S_ERR;
`endif
            end else begin
              // Wait counter saturates at 0 while an SSP access waits for ready.
              if (wcnt_q != '0) begin
                wcnt_q <= wcnt_q - CW'(1);
              end
`ifdef WB_SLV_TIMEOUT_EN
              if (ssp_q) begin
                tmo_q <= tmo_q + TW'(1);
              end
`endif
            end
          end
          S_ACK:   state_q <= S_IDLE;
          S_ERR:   state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Write acks present zero; the last read value reappears afterwards.
  assign wb.dat_o  = (ack_q && we_q) ? '0 : rdata_q;
  assign wb.ack_o  = ack_q;
  assign wb.tagd_o = tagd_q;

  assign mem_adr_o = adr_q;
  assign mem_sel_o = sel_q;
  assign mem_dat_o = wdat_q;
  assign mem_r_o   = mem_r_q;
  assign mem_w_o   = mem_w_q;
  assign ssp_dat_o = wdat_q[NARROW_W-1:0];
  assign ssp_sel_o = ssp_sel_q;
  assign ssp_w_o   = ssp_w_q;
endmodule

// File: tb/tb_wb_slave_bridge.sv
// Self-checking bench for wb_slave_bridge: scoreboard of expected completions plus cycle-level strobe checks.
// Covers the WB_SLV_TIMEOUT_EN build when that macro is defined.
module tb_wb_slave_bridge;
  localparam int DW   = 32;
  localparam int AW   = 26;
  localparam int MAXC = 64;

  typedef struct {
    logic        is_err;
    logic [31:0] dat;
    logic        tagd;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   mem_adr_o;
  logic [DW/8-1:0] mem_sel_o;
  logic [DW-1:0]   mem_dat_o;
  logic [DW-1:0]   mem_dat_i;
  logic            mem_r_o;
  logic            mem_w_o;
  logic [7:0]      ssp_dat_o;
  logic [7:0]      ssp_dat_i;
  logic            ssp_rdy_i;
  logic            ssp_sel_o;
  logic            ssp_w_o;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  exp_t sb_q[$];
  logic [31:0] last_rd = 32'h0;

  wb_slave_bridge_if #(.DW(DW), .AW(AW)) wb ();

  wb_slave_bridge #(
    .DW(DW), .AW(AW), .SEL_BIT(16), .NARROW_W(8), .WAIT_CYC(1), .TMO_CYC(8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .wb        (wb),
    .mem_adr_o (mem_adr_o),
    .mem_sel_o (mem_sel_o),
    .mem_dat_o (mem_dat_o),
    .mem_dat_i (mem_dat_i),
    .mem_r_o   (mem_r_o),
    .mem_w_o   (mem_w_o),
    .ssp_dat_o (ssp_dat_o),
    .ssp_dat_i (ssp_dat_i),
    .ssp_rdy_i (ssp_rdy_i),
    .ssp_sel_o (ssp_sel_o),
    .ssp_w_o   (ssp_w_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // One transfer: request driven after a rising edge (cycle 0), completion awaited for at most MAXC cycles.
  task automatic xfer(input logic we, input logic [AW-1:0] adr, input logic [3:0] sel,
                      input logic [31:0] wdat, input int rdy_dly, input logic exp_err,
                      input int exp_lat, input string name,
                      output logic [63:0] h_memr, output logic [63:0] h_memw,
                      output logic [63:0] h_sel, output logic [63:0] h_sw);
    exp_t e;
    exp_t g;
    bit   seen = 0;
    bit   excl_bad = 0;
    int   lat = -1;
    h_memr = '0; h_memw = '0; h_sel = '0; h_sw = '0;
    e.is_err = exp_err;
    if (exp_err) begin
      e.dat = last_rd; e.tagd = 1'b0;
    end else if (we) begin
      e.dat = 32'h0; e.tagd = 1'b0;
    end else begin
      e.dat   = adr[16] ? {24'h0, ssp_dat_i} : mem_dat_i;
      e.tagd  = adr[16];
      last_rd = e.dat;
    end
    @(posedge clk); #1;
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = we;
    wb.adr_i = adr;  wb.sel_i = sel;  wb.dat_i = wdat;
    sb_q.push_back(e);
    for (int n = 0; n < MAXC; n++) begin
      @(negedge clk);
      ssp_rdy_i = (n >= rdy_dly);
      h_memr[n] = mem_r_o; h_memw[n] = mem_w_o; h_sel[n] = ssp_sel_o; h_sw[n] = ssp_w_o;
      if (wb.ack_o && wb.err_o) excl_bad = 1;
      if ((mem_r_o || mem_w_o) && (ssp_sel_o || ssp_w_o)) excl_bad = 1;
      if (wb.ack_o || wb.err_o) begin
        seen = 1;
        lat  = n;
        break;
      end
    end
    // Scramble master inputs now; the DUT must use its latched copies.
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = ~we; wb.adr_i = ~adr; wb.sel_i = ~sel; wb.dat_i = ~wdat;
    ssp_rdy_i = 1'b0;
    g = sb_q.pop_front();
    chk_cnt++;
    if (!seen) begin
      $display("FAIL %s_done: no ack_o/err_o within %0d cycles, required one", name, MAXC);
    end else begin
      pass_cnt++;
      $display("xfer %s we=%0b adr=%h lat=%0d ack=%0b err=%0b dat_o=%h tagd=%0b",
               name, we, adr, lat, wb.ack_o, wb.err_o, wb.dat_o, wb.tagd_o);
      chk_cnt++;
      if ({wb.ack_o, wb.err_o} !== {~g.is_err, g.is_err})
        $display("FAIL %s_kind: ack/err=%b%b required %b%b", name, wb.ack_o, wb.err_o, ~g.is_err, g.is_err);
      else pass_cnt++;
      chk_cnt++;
      if (wb.dat_o !== g.dat) $display("FAIL %s_dat: dat_o=%h required %h", name, wb.dat_o, g.dat);
      else pass_cnt++;
      chk_cnt++;
      if (wb.tagd_o !== g.tagd) $display("FAIL %s_tagd: tagd_o=%b required %b", name, wb.tagd_o, g.tagd);
      else pass_cnt++;
      chk_cnt++;
      if (lat != exp_lat) $display("FAIL %s_lat: latency=%0d required %0d", name, lat, exp_lat);
      else pass_cnt++;
    end
    chk_cnt++;
    if (excl_bad) $display("FAIL %s_excl: exclusive outputs overlapped=1 required 0", name);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wb.cyc_i = 0; wb.stb_i = 0; wb.we_i = 0; wb.adr_i = '0; wb.sel_i = '0; wb.dat_i = '0;
    mem_dat_i = '0; ssp_dat_i = '0; ssp_rdy_i = 0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({wb.dat_o, wb.ack_o, wb.err_o, wb.tagd_o, mem_adr_o, mem_sel_o, mem_dat_o, ssp_dat_o} !== '0)
      $display("FAIL reset_data: outputs=%h required 0",
               {wb.dat_o, wb.ack_o, wb.err_o, wb.tagd_o, mem_adr_o, mem_sel_o, mem_dat_o, ssp_dat_o});
    else pass_cnt++;
    chk_cnt++;
    if ({mem_r_o, mem_w_o, ssp_sel_o, ssp_w_o} !== 4'b0)
      $display("FAIL reset_strobes: strobes=%b required 0000", {mem_r_o, mem_w_o, ssp_sel_o, ssp_w_o});
    else pass_cnt++;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_mem_read();
    logic [63:0] hr, hw, hs, hsw;
    mem_dat_i = 32'hDEADBEEF;
    xfer(1'b0, 26'h0000100, 4'hF, 32'h0, 0, 1'b0, 3, "mem_rd", hr, hw, hs, hsw);
    chk_cnt++;
    if (hr !== 64'h6) $display("FAIL mem_rd_strobe: mem_r_o history=%h required 6", hr); else pass_cnt++;
    chk_cnt++;
    if ({hw, hs, hsw} !== '0) $display("FAIL mem_rd_other: other strobes=%h required 0", {hw, hs, hsw}); else pass_cnt++;
    chk_cnt++;
    if (mem_adr_o !== 26'h0000100) $display("FAIL mem_rd_adr: mem_adr_o=%h required 0000100", mem_adr_o); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({wb.ack_o, wb.dat_o} !== {1'b0, 32'hDEADBEEF})
      $display("FAIL mem_rd_hold: ack/dat_o=%b/%h required 0/deadbeef", wb.ack_o, wb.dat_o);
    else pass_cnt++;
  endtask

  task automatic test_mem_write();
    logic [63:0] hr, hw, hs, hsw;
    mem_dat_i = 32'h0BADF00D;
    xfer(1'b1, 26'h0000204, 4'b0011, 32'h12345678, 0, 1'b0, 3, "mem_wr", hr, hw, hs, hsw);
    chk_cnt++;
    if (hw !== 64'h6) $display("FAIL mem_wr_strobe: mem_w_o history=%h required 6", hw); else pass_cnt++;
    chk_cnt++;
    if ({hr, hs, hsw} !== '0) $display("FAIL mem_wr_other: other strobes=%h required 0", {hr, hs, hsw}); else pass_cnt++;
    chk_cnt++;
    if ({mem_dat_o, mem_sel_o, mem_adr_o} !== {32'h12345678, 4'b0011, 26'h0000204})
      $display("FAIL mem_wr_latch: dat/sel/adr=%h/%b/%h required 12345678/0011/0000204", mem_dat_o, mem_sel_o, mem_adr_o);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({wb.ack_o, wb.dat_o} !== {1'b0, last_rd})
      $display("FAIL mem_wr_hold: ack/dat_o=%b/%h required 0/%h", wb.ack_o, wb.dat_o, last_rd);
    else pass_cnt++;
  endtask

  task automatic test_ssp_read();
    logic [63:0] hr, hw, hs, hsw;
    ssp_dat_i = 8'hA5;
    xfer(1'b0, 26'h0010000, 4'hF, 32'h0, 5, 1'b0, 6, "ssp_rd", hr, hw, hs, hsw);
    chk_cnt++;
    if (hs !== 64'h3E) $display("FAIL ssp_rd_sel: ssp_sel_o history=%h required 3e", hs); else pass_cnt++;
    chk_cnt++;
    if ({hr, hw, hsw} !== '0) $display("FAIL ssp_rd_other: other strobes=%h required 0", {hr, hw, hsw}); else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ssp_write();
    logic [63:0] hr, hw, hs, hsw;
    xfer(1'b1, 26'h0010008, 4'hF, 32'hABCDEF3C, 2, 1'b0, 3, "ssp_wr", hr, hw, hs, hsw);
    chk_cnt++;
    if ({hs, hsw} !== {64'h6, 64'h6}) $display("FAIL ssp_wr_strobe: sel/w history=%h/%h required 6/6", hs, hsw); else pass_cnt++;
    chk_cnt++;
    if (ssp_dat_o !== 8'h3C) $display("FAIL ssp_wr_dat: ssp_dat_o=%h required 3c", ssp_dat_o); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (wb.dat_o !== 32'h000000A5) $display("FAIL ssp_wr_hold: dat_o=%h required 000000a5", wb.dat_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] hr, hw, hs, hsw;
    mem_dat_i = 32'hCAFE0001;
    xfer(1'b0, 26'h0000010, 4'hF, 32'h0, 0, 1'b0, 3, "b2b_rd0", hr, hw, hs, hsw);
    ssp_dat_i = 8'h5A;
    xfer(1'b0, 26'h0010004, 4'hF, 32'h0, 0, 1'b0, 3, "b2b_ssp", hr, hw, hs, hsw);
    xfer(1'b1, 26'h0000020, 4'b1100, 32'h0F0F0F0F, 0, 1'b0, 3, "b2b_wr", hr, hw, hs, hsw);
    mem_dat_i = 32'hCAFE0002;
    xfer(1'b0, 26'h0000030, 4'hF, 32'h0, 0, 1'b0, 3, "b2b_rd1", hr, hw, hs, hsw);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    logic [63:0] hr, hw, hs, hsw;
    logic [31:0] prev;
    prev = last_rd;
    mem_dat_i = 32'h11112222;
    @(posedge clk); #1;
    wb.cyc_i = 1; wb.stb_i = 1; wb.we_i = 0; wb.adr_i = 26'h0000300; wb.sel_i = 4'hF;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (mem_r_o !== 1'b1) $display("FAIL abort_wait: mem_r_o=%b required 1", mem_r_o); else pass_cnt++;
    wb.cyc_i = 0; wb.stb_i = 0;
    @(negedge clk);
    chk_cnt++;
    if ({wb.ack_o, wb.err_o, mem_r_o} !== 3'b000)
      $display("FAIL abort_drop: ack/err/mem_r=%b%b%b required 000", wb.ack_o, wb.err_o, mem_r_o);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({wb.ack_o, wb.dat_o} !== {1'b0, prev})
      $display("FAIL abort_dat: ack/dat_o=%b/%h required 0/%h", wb.ack_o, wb.dat_o, prev);
    else pass_cnt++;
    mem_dat_i = 32'h33334444;
    xfer(1'b0, 26'h0000304, 4'hF, 32'h0, 0, 1'b0, 3, "post_abort", hr, hw, hs, hsw);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    logic [63:0] hr, hw, hs, hsw;
    mem_dat_i = 32'h55556666;
    @(posedge clk); #1;
    wb.cyc_i = 1; wb.stb_i = 1; wb.we_i = 0; wb.adr_i = 26'h0000400; wb.sel_i = 4'hF;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({mem_r_o, wb.ack_o, wb.dat_o, mem_adr_o} !== '0)
      $display("FAIL rst_wait: mem_r/ack/dat_o/adr=%b/%b/%h/%h required all 0", mem_r_o, wb.ack_o, wb.dat_o, mem_adr_o);
    else pass_cnt++;
    last_rd = 32'h0;
    wb.cyc_i = 0; wb.stb_i = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    mem_dat_i = 32'h77778888;
    xfer(1'b0, 26'h0000408, 4'hF, 32'h0, 0, 1'b0, 3, "post_rst", hr, hw, hs, hsw);
    repeat (2) @(negedge clk);
  endtask

`ifdef WB_SLV_TIMEOUT_EN
  task automatic test_timeout();
    logic [63:0] hr, hw, hs, hsw;
    ssp_dat_i = 8'hEE;
    xfer(1'b0, 26'h0010010, 4'hF, 32'h0, 1000, 1'b1, 10, "ssp_tmo", hr, hw, hs, hsw);
    chk_cnt++;
    if (hs !== 64'h3FE) $display("FAIL tmo_sel: ssp_sel_o history=%h required 3fe", hs); else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({wb.err_o, ssp_sel_o} !== 2'b00)
      $display("FAIL tmo_after: err/ssp_sel=%b%b required 00", wb.err_o, ssp_sel_o);
    else pass_cnt++;
    ssp_dat_i = 8'h3D;
    xfer(1'b0, 26'h0010014, 4'hF, 32'h0, 0, 1'b0, 3, "post_tmo", hr, hw, hs, hsw);
  endtask
`else
  task automatic test_ssp_long_wait();
    logic [63:0] hr, hw, hs, hsw;
    ssp_dat_i = 8'hEE;
    xfer(1'b0, 26'h0010010, 4'hF, 32'h0, 20, 1'b0, 21, "ssp_long", hr, hw, hs, hsw);
    chk_cnt++;
    if (hs !== 64'h1FFFFE) $display("FAIL long_sel: ssp_sel_o history=%h required 1ffffe", hs); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_ssp_read();
    test_ssp_write();
    test_back_to_back();
    test_abort();
    test_reset_in_wait();
`ifdef WB_SLV_TIMEOUT_EN
    test_timeout();
`else
    test_ssp_long_wait();
`endif
    chk_cnt++;
    if (sb_q.size() != 0) $display("FAIL sb_empty: %0d entries left, required 0", sb_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
